// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the iterative multiply/divide unit: RV32M funct3
// op codes, FSM state encodings and operand-signedness decode helpers.
package mdu_seq_pkg;

  // RV32M funct3 op codes (shared with decode and writeback)
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_FIX  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  // rs1 is treated as signed for every op except MULHU, DIVU and REMU
  function automatic logic op_signed_a(input logic [2:0] op);
    logic s;
    case (op)
      MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: s = 1'b1;
      default:                                         s = 1'b0;
    endcase
    return s;
  endfunction

  // rs2 is treated as signed only for MUL, MULH, DIV and REM
  function automatic logic op_signed_b(input logic [2:0] op);
    logic s;
    case (op)
      MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: s = 1'b1;
      default:                             s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide unit. One operation in flight, fixed
// latency: XLEN CALC cycles over operand magnitudes, then one FIX cycle for
// sign correction and special cases, then a one-cycle DONE pulse.
// Multiply uses a right-shifting shift-add over {hi,lo} (lo holds |a| as the
// multiplier, |b| is the multiplicand). Divide uses left-shifting restoring
// division over {hi,lo} (lo holds the dividend and collects quotient bits,
// hi holds the partial remainder). One adder/subtractor serves both.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_i,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_o
);

  localparam int CW = $clog2(XLEN);

  logic [1:0]      state_q,  state_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic [2:0]      op_q,     op_d;
  logic [4:0]      rd_q,     rd_d;
  logic [XLEN-1:0] opb_q,    opb_d;
  logic [XLEN-1:0] hi_q,     hi_d;
  logic [XLEN-1:0] lo_q,     lo_d;
  logic            sa_q,     sa_d;
  logic            sb_q,     sb_d;
  logic            busy_q,   busy_d;
  logic            done_q,   done_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_o_q,   rd_o_d;

  logic [XLEN:0]     shifted_s;
  logic [XLEN+1:0]   step_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   fix_res_s;

  // Two's complement negation at operand width
  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Two's complement negation at product width
  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of an operand given its effective sign flag
  function automatic logic [XLEN-1:0] mag_x(input logic [XLEN-1:0] v, input logic neg);
    logic [XLEN-1:0] m;
    if (neg) begin
      m = neg_x(v);
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Shared adder: trial subtraction of the divisor, or conditional add of the multiplicand
  always_comb begin
    shifted_s = {hi_q, lo_q[XLEN-1]};
    step_s    = '0;
    if (op_q[2]) begin
      step_s = {1'b0, shifted_s} - {2'b00, opb_q};
    end else if (lo_q[0]) begin
      step_s = {2'b00, hi_q} + {2'b00, opb_q};
    end else begin
      step_s = {2'b00, hi_q};
    end
  end

  // Sign correction and special cases applied in FIX
  always_comb begin
    fix_res_s = '0;
    if ((sa_q ^ sb_q) == 1'b1) begin
      prod_s = neg_2x({hi_q, lo_q});
    end else begin
      prod_s = {hi_q, lo_q};
    end
    case (op_q)
      MDU_MUL: begin
        fix_res_s = prod_s[XLEN-1:0];
      end
      MDU_MULH, MDU_MULHSU, MDU_MULHU: begin
        fix_res_s = prod_s[2*XLEN-1:XLEN];
      end
      MDU_DIV, MDU_DIVU: begin
        // Divide by zero returns all ones. The signed overflow case
        // (most-negative / -1) needs no special path: the magnitude quotient
        // is 2^(XLEN-1) with positive sign, which is the required result.
        if (opb_q == '0) begin
          fix_res_s = '1;
        end else if ((sa_q ^ sb_q) == 1'b1) begin
          fix_res_s = neg_x(lo_q);
        end else begin
          fix_res_s = lo_q;
        end
      end
      MDU_REM, MDU_REMU: begin
        // Remainder takes the dividend sign; with a zero divisor the
        // remainder magnitude is |a|, so this also yields a unchanged.
        fix_res_s = mag_x(hi_q, sa_q);
      end
      default: begin
        fix_res_s = '0;
      end
    endcase
  end

  // FSM and datapath next-state: launch, iterate, fix up, report
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    rd_o_d   = rd_o_q;
    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_CALC;
            op_d    = op;
            rd_d    = rd_i;
            sa_d    = op_signed_a(op) & a[XLEN-1];
            sb_d    = op_signed_b(op) & b[XLEN-1];
            lo_d    = mag_x(a, op_signed_a(op) & a[XLEN-1]);
            opb_d   = mag_x(b, op_signed_b(op) & b[XLEN-1]);
            hi_d    = '0;
            cnt_d   = CW'(XLEN - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CALC: begin
          if (op_q[2]) begin
            if (step_s[XLEN+1] == 1'b0) begin
              hi_d = step_s[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_d = shifted_s[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_d = step_s[XLEN:1];
            lo_d = {step_s[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == '0) begin
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_FIX: begin
          result_d = fix_res_s;
          rd_o_d   = rd_q;
          state_d  = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_o_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      rd_o_q   <= rd_o_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_o   = rd_o_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed plus randomised bench for mdu_seq. Expected results are pushed to
// a scoreboard queue when an operation is launched and popped on done.
module tb_mdu_seq;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd_i;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_o;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb_q[$];
  int          checks;
  int          errors;
  logic [31:0] last_res;
  logic [4:0]  last_rd;
  int          done_seen;
  logic [2:0]  ro;
  logic [31:0] ra;
  logic [31:0] rb;

  mdu_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .rd_i   (rd_i),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_o   (rd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog so the run always terminates
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Independent reference model built on native SV arithmetic
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    int          sx;
    int          sy;
    logic [31:0] r;
    sx = x;
    sy = y;
    r  = 32'h0;
    case (o)
      3'b000: begin p = {32'h0, x} * {32'h0, y}; r = p[31:0]; end
      3'b001: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; r = p[63:32]; end
      3'b010: begin p = {{32{x[31]}}, x} * {32'h0, y}; r = p[63:32]; end
      3'b011: begin p = {32'h0, x} * {32'h0, y}; r = p[63:32]; end
      3'b100: begin
        if (y == 32'h0) r = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = sx / sy;
      end
      3'b101: begin
        if (y == 32'h0) r = 32'hFFFF_FFFF;
        else r = x / y;
      end
      3'b110: begin
        if (y == 32'h0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h0;
        else r = sx % sy;
      end
      default: begin
        if (y == 32'h0) r = x;
        else r = x % y;
      end
    endcase
    return r;
  endfunction

  // Launch from the current negedge, wait (bounded) for done, score it
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] t, input logic [31:0] exp_r,
                        input bit chk_lat, input bit noise);
    exp_t e;
    int   lat;
    int   bc;
    bit   got;
    op    = o;
    a     = x;
    b     = y;
    rd_i  = t;
    start = 1'b1;
    sb_q.push_back('{res: exp_r, rd: t});
    lat = 0;
    bc  = 0;
    got = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = noise && (c == 5 || c == 20);
      if (start) begin
        op   = 3'b101;
        a    = $urandom;
        b    = $urandom;
        rd_i = 5'd31;
      end
      if (done) begin
        lat = c;
        got = 1'b1;
        break;
      end
      if (busy) bc++;
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    if (got) begin
      e = sb_q.pop_front();
      check({tag, "_result"}, 64'(result), 64'(e.res));
      check({tag, "_rd"}, 64'(rd_o), 64'(e.rd));
      last_res = e.res;
      last_rd  = e.rd;
      if (chk_lat) begin
        check({tag, "_latency"}, 64'(lat), 64'd34);
        check({tag, "_busy_cycles"}, 64'(bc), 64'd33);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rstn     = 1'b0;
    start    = 1'b0;
    kill     = 1'b0;
    op       = 3'b000;
    a        = 32'h0;
    b        = 32'h0;
    rd_i     = 5'd0;
    last_res = 32'h0;
    last_rd  = 5'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_rd", 64'(rd_o), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Multiply variants
    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b1, 1'b0);
    @(negedge clk);
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 1'b1, 1'b0);
    @(negedge clk);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    @(negedge clk);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk);

    // Divide variants
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 1'b1, 1'b0);
    @(negedge clk);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk);
    run_op("divu", 3'b101, 32'd100, 32'd7, 5'd11, 32'd14, 1'b0, 1'b0);
    @(negedge clk);
    run_op("remu", 3'b111, 32'd100, 32'd7, 5'd12, 32'd2, 1'b0, 1'b0);
    @(negedge clk);

    // Special cases
    run_op("div_by0", 3'b100, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1'b1, 1'b0);
    @(negedge clk);
    run_op("remu_by0", 3'b111, 32'd5, 32'd0, 5'd14, 32'd5, 1'b0, 1'b0);
    @(negedge clk);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b1, 1'b0);
    @(negedge clk);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0, 1'b0, 1'b0);
    @(negedge clk);

    // Kill 10 cycles into CALC; a start in the kill cycle is dropped
    done_seen = 0;
    op    = 3'b000;
    a     = 32'd3;
    b     = 32'd4;
    rd_i  = 5'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    kill  = 1'b1;
    start = 1'b1;
    op    = 3'b101;
    a     = 32'd50;
    b     = 32'd5;
    rd_i  = 5'd21;
    @(negedge clk);
    kill  = 1'b0;
    start = 1'b0;
    if (done) done_seen++;
    check("kill_busy", 64'(busy), 64'd0);
    check("kill_done", 64'(done_seen), 64'd0);
    check("kill_result", 64'(result), 64'(last_res));
    check("kill_rd", 64'(rd_o), 64'(last_rd));
    run_op("after_kill", 3'b101, 32'd50, 32'd5, 5'd22, 32'd10, 1'b1, 1'b0);
    @(negedge clk);

    // Reset mid-CALC clears every output
    op    = 3'b000;
    a     = 32'd9;
    b     = 32'd9;
    rd_i  = 5'd23;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_rd", 64'(rd_o), 64'd0);
    rstn     = 1'b1;
    last_res = 32'h0;
    last_rd  = 5'd0;
    @(negedge clk);

    // Start pulses while busy are ignored
    run_op("busy_start", 3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd24,
           model(3'b011, 32'h1234_5678, 32'h9ABC_DEF0), 1'b1, 1'b1);
    @(negedge clk);

    // Back-to-back: second start issued in the DONE cycle
    run_op("b2b_first", 3'b001, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd25,
           model(3'b001, 32'hDEAD_BEEF, 32'h0BAD_F00D), 1'b1, 1'b0);
    run_op("b2b_second", 3'b110, 32'hF000_0001, 32'd12345, 5'd26,
           model(3'b110, 32'hF000_0001, 32'd12345), 1'b1, 1'b0);
    @(negedge clk);

    // Random operands across all ops
    for (int i = 0; i < 16; i++) begin
      ro = 3'(i % 8);
      ra = $urandom;
      rb = (i == 5 || i == 14) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      run_op("rand", ro, ra, rb, 5'(i), model(ro, ra, rb), 1'b0, 1'b0);
      @(negedge clk);
    end

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
